// File: rtl/sum_window_accumulator.sv
// sum_window_accumulator
//   Accumulates a programmable window (1..255) of byte-sum samples into a
//   wide running total and presents the result on a held valid/ready port.
//
//   Ports:
//     clk, rst              clock, synchronous active-high reset
//     in_data/in_valid/in_ready   sample stream (ready decoded from state only)
//     win_len               window length, 0 treated as 1, sampled at window start
//     flush                 close the current window early (ACCUM only)
//     out_sum/out_count/out_ovf   registered window result
//     out_valid/out_ready   result handshake (valid == HOLD state)
//     busy                  high in ACCUM or HOLD
//
//   Optional feature (macro SUM_WINDOW_MINMAX_EN):
//     adds out_min/out_max, unsigned min/max of the window's samples.
module sum_window_accumulator #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        win_len,
    input  logic              flush,
    output logic [ACC_W-1:0]  out_sum,
    output logic [7:0]        out_count,
    output logic              out_ovf,
`ifdef SUM_WINDOW_MINMAX_EN
    output logic [DATA_W-1:0] out_min,
    output logic [DATA_W-1:0] out_max,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy
);

    localparam int SUM_W = ACC_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic [7:0]        len_q, len_d;
    logic [ACC_W-1:0]  out_sum_q, out_sum_d;
    logic [7:0]        out_count_q, out_count_d;
    logic              out_ovf_q, out_ovf_d;

    logic              accept;
    logic              load_out;
    logic [7:0]        len_w;
    logic [7:0]        cnt_inc;
    logic [SUM_W-1:0]  add_w;

`ifdef SUM_WINDOW_MINMAX_EN
    logic [DATA_W-1:0] min_q, min_d, max_q, max_d;
    logic [DATA_W-1:0] out_min_q, out_min_d, out_max_q, out_max_d;
`endif

    assign in_ready  = (state_q != HOLD);
    assign out_valid = (state_q == HOLD);
    assign busy      = (state_q != IDLE);
    assign accept    = in_valid & in_ready;

    // Resolved window length: a zero length would never terminate, so it
    // behaves as a single-sample window.
    assign len_w   = (win_len == 8'd0) ? 8'd1 : win_len;
    assign cnt_inc = cnt_q + 8'd1;
    // One extra bit captures the carry-out for the sticky overflow flag.
    assign add_w   = {1'b0, acc_q} + SUM_W'(in_data);

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        len_d       = len_q;
        load_out    = 1'b0;
        out_sum_d   = out_sum_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;
`ifdef SUM_WINDOW_MINMAX_EN
        min_d       = min_q;
        max_d       = max_q;
        out_min_d   = out_min_q;
        out_max_d   = out_max_q;
`endif

        case (state_q)
            IDLE: begin
                if (accept) begin
                    len_d = len_w;
                    acc_d = ACC_W'(in_data);
                    cnt_d = 8'd1;
                    ovf_d = 1'b0;
`ifdef SUM_WINDOW_MINMAX_EN
                    min_d = in_data;
                    max_d = in_data;
`endif
                    if (len_w == 8'd1) begin
                        state_d  = HOLD;
                        load_out = 1'b1;
                    end else begin
                        state_d = ACCUM;
                    end
                end
            end
            ACCUM: begin
                if (accept) begin
                    acc_d = add_w[ACC_W-1:0];
                    ovf_d = ovf_q | add_w[ACC_W];
                    cnt_d = cnt_inc;
`ifdef SUM_WINDOW_MINMAX_EN
                    if (in_data < min_q) min_d = in_data;
                    if (in_data > max_q) max_d = in_data;
`endif
                end
                // A sample accepted alongside flush is folded in first.
                if ((accept && (cnt_inc == len_q)) || flush) begin
                    state_d  = HOLD;
                    load_out = 1'b1;
                end
            end
            HOLD: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Result registers only change on entry to HOLD, so they stay stable
        // for the whole HOLD and keep the last window through IDLE/ACCUM.
        if (load_out) begin
            out_sum_d   = acc_d;
            out_count_d = cnt_d;
            out_ovf_d   = ovf_d;
`ifdef SUM_WINDOW_MINMAX_EN
            out_min_d   = min_d;
            out_max_d   = max_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            len_q       <= '0;
            out_sum_q   <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
`ifdef SUM_WINDOW_MINMAX_EN
            min_q       <= '0;
            max_q       <= '0;
            out_min_q   <= '0;
            out_max_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            len_q       <= len_d;
            out_sum_q   <= out_sum_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
`ifdef SUM_WINDOW_MINMAX_EN
            min_q       <= min_d;
            max_q       <= max_d;
            out_min_q   <= out_min_d;
            out_max_q   <= out_max_d;
`endif
        end
    end

    assign out_sum   = out_sum_q;
    assign out_count = out_count_q;
    assign out_ovf   = out_ovf_q;
`ifdef SUM_WINDOW_MINMAX_EN
    assign out_min   = out_min_q;
    assign out_max   = out_max_q;
`endif

endmodule

// File: tb/tb_sum_window_accumulator.sv
// Directed bench for sum_window_accumulator: a default-width instance and an
// ACC_W=9 instance for the wrap/overflow case.
module tb_sum_window_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    // default instance
    logic [7:0]  in_data, win_len;
    logic        in_valid, in_ready, flush, out_valid, out_ready, busy, out_ovf;
    logic [15:0] out_sum;
    logic [7:0]  out_count;
    // ACC_W=9 instance
    logic [7:0]  in_data9, win_len9;
    logic        in_valid9, in_ready9, flush9, out_valid9, out_ready9, busy9, out_ovf9;
    logic [8:0]  out_sum9;
    logic [7:0]  out_count9;
`ifdef SUM_WINDOW_MINMAX_EN
    logic [7:0]  out_min, out_max, out_min9, out_max9;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    sum_window_accumulator u_dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .win_len(win_len), .flush(flush),
        .out_sum(out_sum), .out_count(out_count), .out_ovf(out_ovf),
`ifdef SUM_WINDOW_MINMAX_EN
        .out_min(out_min), .out_max(out_max),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
    );

    sum_window_accumulator #(.DATA_W(8), .ACC_W(9)) u_dut9 (
        .clk(clk), .rst(rst), .in_data(in_data9), .in_valid(in_valid9),
        .in_ready(in_ready9), .win_len(win_len9), .flush(flush9),
        .out_sum(out_sum9), .out_count(out_count9), .out_ovf(out_ovf9),
`ifdef SUM_WINDOW_MINMAX_EN
        .out_min(out_min9), .out_max(out_max9),
`endif
        .out_valid(out_valid9), .out_ready(out_ready9), .busy(busy9)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // advance one clock; inputs change and outputs are sampled 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_data = 0; in_valid = 0; win_len = 0; flush = 0; out_ready = 1;
        in_data9 = 0; in_valid9 = 0; win_len9 = 0; flush9 = 0; out_ready9 = 1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy",      busy,      0);
        chk("rst_out_sum",   out_sum,   0);
        chk("rst_out_count", out_count, 0);
        chk("rst_out_ovf",   out_ovf,   0);
        chk("rst_in_ready",  in_ready,  1);

        // window of 4: 10,20,30,40
        win_len = 8'd4; in_valid = 1;
        in_data = 8'd10; tick();
        chk("w4_busy_accum", busy, 1);
        chk("w4_no_valid",   out_valid, 0);
        win_len = 8'd7;  // ignored mid-window
        in_data = 8'd20; tick();
        in_data = 8'd30; tick();
        in_data = 8'd40; tick();
        in_valid = 0;
        chk("w4_out_valid", out_valid, 1);
        chk("w4_out_sum",   out_sum,   100);
        chk("w4_out_count", out_count, 4);
        chk("w4_out_ovf",   out_ovf,   0);
        chk("w4_in_ready",  in_ready,  0);
`ifdef SUM_WINDOW_MINMAX_EN
        chk("w4_out_min", out_min, 10);
        chk("w4_out_max", out_max, 40);
`endif
        tick();
        chk("w4_idle_valid", out_valid, 0);
        chk("w4_idle_busy",  busy,      0);
        chk("w4_idle_ready", in_ready,  1);
        chk("w4_idle_keep",  out_sum,   100);

        // win_len=0 treated as single sample
        win_len = 8'd0; in_data = 8'hFF; in_valid = 1; tick();
        in_valid = 0;
        chk("w0_out_valid", out_valid, 1);
        chk("w0_out_sum",   out_sum,   255);
        chk("w0_out_count", out_count, 1);
        tick();
        chk("w0_idle", out_valid, 0);

        // ACC_W=9 wrap: 600 mod 512 = 88
        win_len9 = 8'd3; in_valid9 = 1; in_data9 = 8'd200;
        tick(); tick(); tick();
        in_valid9 = 0;
        chk("a9_out_valid", out_valid9, 1);
        chk("a9_out_sum",   out_sum9,   88);
        chk("a9_out_ovf",   out_ovf9,   1);
        chk("a9_out_count", out_count9, 3);
        tick();
        chk("a9_idle", out_valid9, 0);

        // flush with a same-cycle sample
        win_len = 8'd10; in_valid = 1;
        in_data = 8'd5; tick();
        in_data = 8'd7; tick();
        in_data = 8'd9; flush = 1; tick();
        in_valid = 0; flush = 0;
        chk("fl_out_valid", out_valid, 1);
        chk("fl_out_sum",   out_sum,   21);
        chk("fl_out_count", out_count, 3);
        tick();
        chk("fl_idle", out_valid, 0);
        flush = 1; tick();
        flush = 0;
        chk("fl_idle_no_valid", out_valid, 0);
        chk("fl_idle_no_busy",  busy,      0);

        // HOLD backpressure with toggling input
        out_ready = 0; win_len = 8'd2; in_valid = 1;
        in_data = 8'd1; tick();
        in_data = 8'd2; tick();
        for (int i = 0; i < 5; i++) begin
            in_data = (i % 2 == 0) ? 8'hAA : 8'h55;
            tick();
            chk("bp_out_valid", out_valid, 1);
            chk("bp_out_sum",   out_sum,   3);
            chk("bp_out_count", out_count, 2);
            chk("bp_in_ready",  in_ready,  0);
        end
        in_valid = 0; out_ready = 1; tick();
        chk("bp_idle", out_valid, 0);
        win_len = 8'd1; in_data = 8'd6; in_valid = 1; tick();
        in_valid = 0;
        chk("bp_fresh_sum",   out_sum,   6);
        chk("bp_fresh_count", out_count, 1);
        chk("bp_fresh_ovf",   out_ovf,   0);
        tick();

        // reset mid-window
        win_len = 8'd5; in_valid = 1;
        in_data = 8'd50; tick();
        in_data = 8'd60; tick();
        in_valid = 0;
        chk("mr_busy_pre", busy, 1);
        rst = 1; tick();
        rst = 0;
        chk("mr_out_valid", out_valid, 0);
        chk("mr_busy",      busy,      0);
        chk("mr_out_sum",   out_sum,   0);
        win_len = 8'd2; in_valid = 1;
        in_data = 8'd3; tick();
        in_data = 8'd4; tick();
        in_valid = 0;
        chk("mr_after_valid", out_valid, 1);
        chk("mr_after_sum",   out_sum,   7);
        chk("mr_after_count", out_count, 2);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/sum_window_accumulator.md
Name: sum_window_accumulator

Overview:
- Downstream stage of the chip's 8-bit byte-sum datapath.
- Consumes the stream of sum bytes through a valid/ready handshake.
- Accumulates a programmable window of 1..255 samples into a wide running total.
- Presents the window result (sum, sample count, overflow flag) on a held valid/ready output for the output-pin mux or readback logic.

Parameters:
- DATA_W, 8, width of each incoming sum sample.
- ACC_W, 16, accumulator and out_sum width; must be >= DATA_W.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- in_data  input  DATA_W  sum sample from the adder stage.
- in_valid  input  1  in_data valid.
- in_ready  output  1  block accepts a sample this cycle.
- win_len  input  8  window length in samples; 0 is treated as 1; sampled only at window start.
- flush  input  1  close the current window early.
- out_sum  output  ACC_W  window total, modulo 2^ACC_W.
- out_count  output  8  samples accumulated in the window.
- out_ovf  output  1  sticky: accumulator carried out at least once in the window.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer takes the result.
- busy  output  1  high in ACCUM or HOLD.

Behaviour:
- Synchronous reset (rst=1 at the clock edge):
  - State goes to IDLE.
  - acc, cnt, ovf and len_q clear to 0.
  - out_valid=0, out_sum=0, out_count=0, out_ovf=0, busy=0.
- A sample is accepted when in_valid & in_ready at a clock edge.
- States: IDLE, ACCUM, HOLD. in_ready is decoded from state only: 1 in IDLE and ACCUM, 0 in HOLD. It never depends on out_ready.
- IDLE, on accept:
  - len_q <= (win_len==0 ? 1 : win_len); acc <= zero-extended in_data; cnt <= 1; ovf <= 0.
  - Next state is HOLD if len_q resolves to 1, else ACCUM.
- ACCUM, on accept:
  - acc <= acc + in_data, wrapping modulo 2^ACC_W; ovf <= ovf | carry-out; cnt <= cnt+1.
  - When the new cnt equals len_q, go to HOLD.
- flush in ACCUM:
  - Go to HOLD with current values.
  - If a sample is accepted in the same cycle, it is included first, then the window closes.
- flush in IDLE or HOLD: ignored.
- HOLD:
  - out_valid=1.
  - out_sum, out_count and out_ovf are register outputs and stay stable while out_valid & !out_ready.
  - in_valid is ignored. On out_ready, go to IDLE next cycle.
- Latency: out_valid rises on the edge that accepts the last sample (or registers flush). The result is visible the cycle after the final sample is presented.
- Throughput: at least one bubble cycle per window (HOLD never accepts input).
- out_* keep the last window's values in IDLE and ACCUM. Only out_valid qualifies them.
- Changes to win_len during ACCUM or HOLD have no effect.
- rst mid-window or mid-HOLD discards the partial or pending result. No output is produced for it.
- Accumulation on cnt overflow is impossible, since len_q <= 255.

Optional Feature:
- Macro: SUM_WINDOW_MINMAX_EN.
- When defined:
  - Adds output ports out_min [DATA_W] and out_max [DATA_W], both reset to 0.
  - The first sample of a window loads both.
  - Each later accepted sample updates min/max with unsigned compare.
  - Values are held with out_sum in HOLD.
- When undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
- win_len=4, feed 10,20,30,40 back-to-back, out_ready=1:
  - out_valid=1 the cycle after 40; out_sum=100, out_count=4, out_ovf=0.
  - in_ready=0 that cycle; IDLE next.
- win_len=0, feed 0xFF:
  - Single-sample window; out_sum=255, out_count=1, HOLD reached directly from IDLE.
- ACC_W=9, win_len=3, feed 200,200,200:
  - out_sum=88 (600 mod 512), out_ovf=1, out_count=3.
- win_len=10, feed 5,7, then 9 with flush asserted in the same cycle:
  - out_sum=21, out_count=3.
  - A flush pulse in IDLE produces no out_valid.
- HOLD with out_ready=0 for 5 cycles while in_valid=1 and in_data toggles:
  - out_* stable, in_ready=0, no sample absorbed.
  - Raise out_ready: IDLE next cycle; the next window starts fresh.
- After 2 accepted samples, assert rst for 1 cycle:
  - out_valid=0, busy=0, out_sum=0.
  - A following win_len=2 window of 3,4 yields out_sum=7, out_count=2.
